// File: rtl/brc_redirect_ctrl_pkg.sv
// Shared definitions for the EX-to-IFU redirect controller: FSM encoding and
// the mask that forces redirect targets onto a 2-byte boundary.
package brc_redirect_ctrl_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REDIR = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [63:0] REDIR_PC_ALIGN_MASK = ~64'd1;

endpackage

// File: rtl/brc_redirect_ctrl_fetch_outst_cnt.sv
// Up/down count of IFU fetch requests still awaiting a response, plus the
// admission signal that keeps the IFU within MAX_OUTST requests in flight.
module fetch_outst_cnt
    import brc_redirect_ctrl_pkg::*;
#(
    parameter int MAX_OUTST = 2,
    parameter int CW        = $clog2(MAX_OUTST + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_fire,
    input  logic          rsp_valid,
    output logic [CW-1:0] outst,
    output logic          req_allow
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTST);

    // Simultaneous request and response cancel out; both ends saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outst <= '0;
        end else if (req_fire && !rsp_valid && outst != MAX_C) begin
            outst <= outst + 1'b1;
        end else if (rsp_valid && !req_fire && outst != '0) begin
            outst <= outst - 1'b1;
        end
    end

    assign req_allow = (outst < MAX_C) | rsp_valid;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(req_fire && !rsp_valid && outst == MAX_C));

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp_valid && outst == '0));

endmodule

// File: rtl/brc_redirect_ctrl.sv
// Turns a resolved taken jump in EX into a flush plus a handshaked IFU
// redirect, then discards fetch responses that were in flight at redirect time.
module brc_redirect_ctrl
    import brc_redirect_ctrl_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int MAX_OUTST = 2,
    localparam int CW       = $clog2(MAX_OUTST + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid_i,
    input  logic            ex_stall_i,
    input  logic            ex_is_jump_i,
    input  logic [XLEN-1:0] ex_target_i,
    output logic            flush_o,
    output logic            ex_hold_o,
    output logic            redir_valid_o,
    output logic [XLEN-1:0] redir_pc_o,
    input  logic            redir_ready_i,
    input  logic            if_req_fire_i,
    input  logic            if_rsp_valid_i,
    output logic            if_rsp_drop_o,
    output logic            if_req_allow_o,
    output logic [31:0]     redir_cnt_o
);

    logic [1:0]    state;
    logic [CW-1:0] outst;
    logic [CW-1:0] drop_cnt;
    logic          capture;
    logic          drop;

    fetch_outst_cnt #(
        .MAX_OUTST (MAX_OUTST),
        .CW        (CW)
    ) u_outst (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_fire  (if_req_fire_i),
        .rsp_valid (if_rsp_valid_i),
        .outst     (outst),
        .req_allow (if_req_allow_o)
    );

    assign capture       = ex_valid_i & ex_is_jump_i & ~ex_stall_i & (state == IDLE);
    assign drop          = (state == DRAIN) & if_rsp_valid_i & (drop_cnt != '0);
    assign redir_valid_o = (state == REDIR);
    assign ex_hold_o     = (state == REDIR) | (state == DRAIN);
    assign if_rsp_drop_o = drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            flush_o     <= 1'b0;
            redir_pc_o  <= '0;
            drop_cnt    <= '0;
            redir_cnt_o <= '0;
        end else begin
            flush_o <= capture;
            case (state)
                IDLE: begin
                    if (capture) begin
                        redir_pc_o <= ex_target_i & REDIR_PC_ALIGN_MASK[XLEN-1:0];
                        state      <= REDIR;
                    end
                end
                REDIR: begin
                    // Requests already in flight at the handshake are stale;
                    // a request firing in the same cycle is the redirect fetch.
                    if (redir_ready_i) begin
                        redir_cnt_o <= redir_cnt_o + 32'd1;
                        drop_cnt    <= outst;
                        state       <= (outst != '0) ? DRAIN : IDLE;
                    end
                end
                DRAIN: begin
                    if (drop) begin
                        drop_cnt <= drop_cnt - 1'b1;
                        if (drop_cnt == CW'(1)) begin
                            state <= IDLE;
                        end
                    end else if (drop_cnt == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_brc_redirect_ctrl.sv
// Scoreboard bench for brc_redirect_ctrl: directed scenarios followed by
// random legal traffic, checked against a transaction-level reference model.
module tb_brc_redirect_ctrl;

    localparam int XLEN      = 64;
    localparam int MAX_OUTST = 2;

    logic            clk;
    logic            rst_n;
    logic            ex_valid_i;
    logic            ex_stall_i;
    logic            ex_is_jump_i;
    logic [XLEN-1:0] ex_target_i;
    logic            flush_o;
    logic            ex_hold_o;
    logic            redir_valid_o;
    logic [XLEN-1:0] redir_pc_o;
    logic            redir_ready_i;
    logic            if_req_fire_i;
    logic            if_rsp_valid_i;
    logic            if_rsp_drop_o;
    logic            if_req_allow_o;
    logic [31:0]     redir_cnt_o;

    brc_redirect_ctrl #(
        .XLEN      (XLEN),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid_i     (ex_valid_i),
        .ex_stall_i     (ex_stall_i),
        .ex_is_jump_i   (ex_is_jump_i),
        .ex_target_i    (ex_target_i),
        .flush_o        (flush_o),
        .ex_hold_o      (ex_hold_o),
        .redir_valid_o  (redir_valid_o),
        .redir_pc_o     (redir_pc_o),
        .redir_ready_i  (redir_ready_i),
        .if_req_fire_i  (if_req_fire_i),
        .if_rsp_valid_i (if_rsp_valid_i),
        .if_rsp_drop_o  (if_rsp_drop_o),
        .if_req_allow_o (if_req_allow_o),
        .redir_cnt_o    (redir_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        hold;
        logic        valid;
        logic [63:0] pc;
        logic        drop;
        logic        allow;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: a redirect is either waiting for the IFU or not, and a
    // number of stale responses may still need discarding.
    bit          m_waiting;
    bit          m_discarding;
    int          m_stale;
    int          m_inflight;
    logic [63:0] m_pc;
    logic [31:0] m_taken;
    bit          m_flush_now;

    task automatic model_reset();
        m_waiting    = 0;
        m_discarding = 0;
        m_stale      = 0;
        m_inflight   = 0;
        m_pc         = '0;
        m_taken      = '0;
        m_flush_now  = 0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus: drive inputs, record what the DUT must show this
    // cycle, then advance the model across the coming edge.
    task automatic cycle(input bit v, input bit s, input bit j, input logic [63:0] tgt,
                         input bit rdy, input bit fire, input bit rsp);
        exp_t e;
        bit   idle;
        @(posedge clk);
        #1;
        ex_valid_i     = v;
        ex_stall_i     = s;
        ex_is_jump_i   = j;
        ex_target_i    = tgt;
        redir_ready_i  = rdy;
        if_req_fire_i  = fire;
        if_rsp_valid_i = rsp;

        e.flush = m_flush_now;
        e.hold  = m_waiting || m_discarding;
        e.valid = m_waiting;
        e.pc    = m_pc;
        e.drop  = m_discarding && rsp && (m_stale > 0);
        e.allow = (m_inflight < MAX_OUTST) || rsp;
        e.cnt   = m_taken;
        exp_q.push_back(e);

        idle        = !m_waiting && !m_discarding;
        m_flush_now = idle && v && j && !s;
        if (m_flush_now) begin
            m_waiting = 1;
            m_pc      = tgt - (tgt % 2);
        end else if (m_waiting && rdy) begin
            m_waiting    = 0;
            m_taken      = m_taken + 1;
            m_stale      = m_inflight;
            m_discarding = (m_inflight > 0);
        end else if (m_discarding) begin
            if (e.drop) m_stale--;
            if (m_stale == 0) m_discarding = 0;
        end

        if (fire && !rsp && m_inflight < MAX_OUTST) m_inflight++;
        else if (rsp && !fire && m_inflight > 0) m_inflight--;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 64'h0, 1, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("flush_o",        {63'd0, flush_o},        {63'd0, e.flush});
                chk("ex_hold_o",      {63'd0, ex_hold_o},      {63'd0, e.hold});
                chk("redir_valid_o",  {63'd0, redir_valid_o},  {63'd0, e.valid});
                chk("redir_pc_o",     redir_pc_o,              e.pc);
                chk("if_rsp_drop_o",  {63'd0, if_rsp_drop_o},  {63'd0, e.drop});
                chk("if_req_allow_o", {63'd0, if_req_allow_o}, {63'd0, e.allow});
                chk("redir_cnt_o",    {32'd0, redir_cnt_o},    {32'd0, e.cnt});
            end
        end
    end

    initial begin : stimulus
        bit          v, s, j, rdy, fire, rsp;
        logic [63:0] tgt;

        rst_n          = 1'b0;
        ex_valid_i     = 1'b0;
        ex_stall_i     = 1'b0;
        ex_is_jump_i   = 1'b0;
        ex_target_i    = '0;
        redir_ready_i  = 1'b0;
        if_req_fire_i  = 1'b0;
        if_rsp_valid_i = 1'b0;
        model_reset();
        #12;
        chk("reset flush_o",        {63'd0, flush_o},        64'd0);
        chk("reset ex_hold_o",      {63'd0, ex_hold_o},      64'd0);
        chk("reset redir_valid_o",  {63'd0, redir_valid_o},  64'd0);
        chk("reset redir_pc_o",     redir_pc_o,              64'd0);
        chk("reset if_req_allow_o", {63'd0, if_req_allow_o}, 64'd1);
        chk("reset redir_cnt_o",    {32'd0, redir_cnt_o},    64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Taken branch, IFU ready, nothing outstanding.
        cycle(1, 0, 1, 64'h8000_0104, 1, 0, 0);
        idle_cycles(3);

        // jalr with an odd target.
        cycle(1, 0, 1, 64'h8000_0203, 1, 0, 0);
        idle_cycles(2);

        // IFU back-pressure for three cycles; EX keeps presenting a jump.
        cycle(1, 0, 1, 64'h0000_1230, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 1, 64'h0000_5550, 0, 0, 0);
        cycle(0, 0, 0, 64'h0, 1, 0, 0);
        idle_cycles(2);

        // Stale drain: two fetches in flight at the handshake.
        cycle(0, 0, 0, 64'h0, 0, 1, 0);
        cycle(0, 0, 0, 64'h0, 0, 1, 0);
        cycle(1, 0, 1, 64'h4000_0010, 0, 0, 0);
        cycle(0, 0, 0, 64'h0, 1, 0, 0);
        cycle(0, 0, 0, 64'h0, 0, 0, 1);
        cycle(0, 0, 0, 64'h0, 0, 0, 1);
        cycle(0, 0, 0, 64'h0, 0, 1, 0);
        cycle(0, 0, 0, 64'h0, 0, 0, 1);
        idle_cycles(2);

        // Stalled EX: no capture until the stall drops.
        cycle(1, 1, 1, 64'h0000_0a00, 1, 0, 0);
        cycle(1, 1, 1, 64'h0000_0a00, 1, 0, 0);
        cycle(1, 0, 1, 64'h0000_0a00, 1, 0, 0);
        idle_cycles(2);

        // Reset mid-drain with one stale response pending and the IFU full.
        cycle(0, 0, 0, 64'h0, 0, 1, 0);
        cycle(1, 0, 1, 64'h0000_7770, 0, 0, 0);
        cycle(0, 0, 0, 64'h0, 1, 1, 0);
        cycle(0, 0, 0, 64'h0, 0, 0, 0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async rst ex_hold_o",      {63'd0, ex_hold_o},      64'd0);
        chk("async rst redir_valid_o",  {63'd0, redir_valid_o},  64'd0);
        chk("async rst redir_pc_o",     redir_pc_o,              64'd0);
        chk("async rst if_req_allow_o", {63'd0, if_req_allow_o}, 64'd1);
        chk("async rst redir_cnt_o",    {32'd0, redir_cnt_o},    64'd0);
        if_rsp_valid_i = 1'b1;
        #1;
        chk("async rst if_rsp_drop_o",  {63'd0, if_rsp_drop_o},  64'd0);
        if_rsp_valid_i = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle_cycles(1);

        // Random legal traffic.
        for (int n = 0; n < 3000; n++) begin
            v    = ($urandom_range(0, 3) != 0);
            s    = ($urandom_range(0, 3) == 0);
            j    = ($urandom_range(0, 3) == 0);
            tgt  = {$urandom, $urandom};
            rdy  = ($urandom_range(0, 4) < 3);
            rsp  = (m_inflight > 0) && ($urandom_range(0, 4) < 2);
            fire = ((m_inflight < MAX_OUTST) || rsp) && ($urandom_range(0, 4) < 2);
            cycle(v, s, j, tgt, rdy, fire, rsp);
        end
        idle_cycles(1);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
